// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with redirect priority and stall-time redirect buffering
//   clk, reset (async, active-high)
//   stall            hold pcout; a redirect seen while stalled is buffered
//   branch_taken/branch_target, jump/jump_target, jr/jr_target  redirect requests (jr > jump > branch)
//   exc              exception request (PC_EXC_EN builds only)
//   pcout            current fetch address
//   pc_plus          pcout + INC
//   redirect_pending a buffered redirect is waiting
//   addr_err         one-cycle pulse after a target with nonzero [1:0] is applied
//   epc              exception PC (PC_EXC_EN builds only)
// Optional feature macro: PC_EXC_EN
module pc_seq #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
`ifdef PC_EXC_EN
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_0180,
`endif
  parameter int unsigned INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
`ifdef PC_EXC_EN
  input  logic             exc,
  output logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] pc_plus,
  output logic             redirect_pending,
  output logic             addr_err
);
  typedef enum logic {RUN, PEND} state_t;
  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_pc, r_pend, w_next_pc, w_next_pend;
  logic             r_err, w_next_err;
  logic             w_req, w_apply;
  logic [WIDTH-1:0] w_tgt, w_src;
`ifdef PC_EXC_EN
  logic [WIDTH-1:0] r_epc, w_next_epc;
`endif
  assign w_req   = jr | jump | branch_taken;
  assign w_tgt   = jr ? jr_target : jump ? jump_target : branch_target;
  // a same-cycle request beats the buffered target; the raw value is kept so addr_err is judged at apply time
  assign w_src   = w_req ? w_tgt : r_pend;
  assign w_apply = w_req | (r_state == PEND);
  assign pc_plus = r_pc + WIDTH'(INC);
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_pend  = r_pend;
    w_next_err   = 1'b0;
`ifdef PC_EXC_EN
    w_next_epc   = r_epc;
`endif
    if (!stall) begin
      w_next_pc    = w_apply ? {w_src[WIDTH-1:2], 2'b00} : pc_plus;
      w_next_err   = w_apply & (|w_src[1:0]);
      w_next_state = RUN;
    end else if (w_req) begin
      w_next_pend  = w_tgt;
      w_next_state = PEND;
    end
`ifdef PC_EXC_EN
    if (exc) begin
      w_next_epc   = r_pc;
      w_next_pc    = EXC_VECTOR;
      w_next_pend  = '0;
      w_next_err   = 1'b0;
      w_next_state = RUN;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_ADDR;
      r_pend  <= '0;
      r_err   <= 1'b0;
`ifdef PC_EXC_EN
      r_epc   <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_pend  <= w_next_pend;
      r_err   <= w_next_err;
`ifdef PC_EXC_EN
      r_epc   <= w_next_epc;
`endif
    end
  end
  assign pcout            = r_pc;
  assign redirect_pending = (r_state == PEND);
  assign addr_err         = r_err;
`ifdef PC_EXC_EN
  assign epc              = r_epc;
`endif
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq (default build)
module tb_pc_seq;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pcout, pc_plus;
  logic        redirect_pending, addr_err;
  int          total = 0;
  int          fails = 0;
  pc_seq dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .pcout(pcout), .pc_plus(pc_plus),
    .redirect_pending(redirect_pending), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input logic [31:0] pc, input logic pend, input logic err, input string tag);
    chk({tag, ".pc"}, pcout, pc);
    chk({tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, pend});
    chk({tag, ".err"}, {31'b0, addr_err}, {31'b0, err});
  endtask
  task automatic req(input logic b, input logic [31:0] bt, input logic j, input logic [31:0] jt, input logic r, input logic [31:0] rt);
    branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    jr = r; jr_target = rt;
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0;
    req(0, 0, 0, 0, 0, 0);
    #1;
    st(32'h0, 0, 0, "reset");
    chk("reset.plus", pc_plus, 32'h4);
    tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    st(32'h10, 0, 0, "seq16");
    #2 reset = 1'b1;
    #1 st(32'h0, 0, 0, "async_reset");
    #1 reset = 1'b0;
    tick(); st(32'h4, 0, 0, "post_rst1");
    tick(); st(32'h8, 0, 0, "post_rst2");
    tick(); st(32'hC, 0, 0, "post_rst3");
    req(0, 0, 1, 32'h20, 0, 0);
    tick(); st(32'h20, 0, 0, "jump20");
    req(1, 32'h400, 0, 0, 0, 0);
    tick(); st(32'h400, 0, 0, "branch");
    req(0, 0, 0, 0, 0, 0);
    tick(); st(32'h404, 0, 0, "branch_seq");
    req(1, 32'hA00, 1, 32'h900, 1, 32'h800);
    tick(); st(32'h800, 0, 0, "prio_jr");
    req(1, 32'hA00, 1, 32'h900, 0, 0);
    tick(); st(32'h900, 0, 0, "prio_jump");
    req(0, 0, 1, 32'h100, 0, 0);
    tick(); st(32'h100, 0, 0, "jump100");
    stall = 1'b1;
    req(0, 0, 1, 32'h300, 0, 0);
    tick(); st(32'h100, 1, 0, "stall_buf");
    req(1, 32'h500, 0, 0, 0, 0);
    tick(); st(32'h100, 1, 0, "stall_overwrite");
    req(0, 0, 0, 0, 0, 0);
    tick(); st(32'h100, 1, 0, "stall_hold");
    stall = 1'b0;
    tick(); st(32'h500, 0, 0, "pend_apply");
    tick(); st(32'h504, 0, 0, "pend_after");
    stall = 1'b1;
    req(0, 0, 1, 32'h600, 0, 0);
    tick(); st(32'h504, 1, 0, "stall2");
    stall = 1'b0;
    req(0, 0, 0, 0, 1, 32'h700);
    tick(); st(32'h700, 0, 0, "new_beats_pend");
    stall = 1'b1;
    req(1, 32'h903, 0, 0, 0, 0);
    tick(); st(32'h700, 1, 0, "mis_latched");
    stall = 1'b0;
    req(0, 0, 0, 0, 0, 0);
    tick(); st(32'h900, 0, 1, "mis_applied");
    tick(); st(32'h904, 0, 0, "mis_cleared");
    req(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick(); st(32'hFFFF_FFFC, 0, 0, "top");
    chk("top.plus", pc_plus, 32'h0);
    req(0, 0, 0, 0, 0, 0);
    tick(); st(32'h0, 0, 0, "wrap");
    req(0, 0, 0, 0, 1, 32'h1006);
    tick(); st(32'h1004, 0, 1, "jr_mis");
    req(0, 0, 0, 0, 0, 0);
    tick(); st(32'h1008, 0, 0, "jr_mis_next");
    stall = 1'b1;
    req(0, 0, 1, 32'h2000, 0, 0);
    tick(); st(32'h1008, 1, 0, "pend_before_rst");
    req(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    #2 reset = 1'b1;
    #1 st(32'h0, 0, 0, "rst_mid_pend");
    #1 reset = 1'b0;
    tick(); st(32'h4, 0, 0, "pend_discarded");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer. Successor to the single-register `pc` block.
- Selects the next fetch address each cycle from four sources: sequential increment, branch, jump and jump-register.
- Holds the PC under stall. If a redirect arrives while stalled, it is buffered and applied on the first unstalled edge.
- Sits between the control unit / branch compare logic and instruction memory in the MIPS datapath.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_0000, value loaded on reset. Lower 2 bits must be 0.
- INC, 4, sequential increment in bytes.
- EXC_VECTOR, 32'h0000_0180, exception vector. Used only with PC_EXC_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; redirects are buffered, not lost
- branch_taken  in  1  one-cycle pulse: redirect to branch_target
- branch_target  in  WIDTH  branch destination
- jump  in  1  one-cycle pulse: redirect to jump_target
- jump_target  in  WIDTH  J/JAL destination
- jr  in  1  one-cycle pulse: redirect to jr_target
- jr_target  in  WIDTH  JR/JALR register value
- exc  in  1  exception request (PC_EXC_EN only)
- pcout  out  WIDTH  current fetch address
- pc_plus  out  WIDTH  pcout + INC, combinational
- redirect_pending  out  1  a buffered redirect is waiting
- addr_err  out  1  one-cycle pulse: an applied target had nonzero bits [1:0]
- epc  out  WIDTH  exception PC (PC_EXC_EN only)

Behaviour:
- Reset (asynchronous, any time, including mid-pending):
  - pcout = RESET_ADDR, redirect_pending = 0, addr_err = 0, epc = 0, FSM = RUN.
  - Any buffered target is discarded.
- Redirect request priority, highest first: jr > jump > branch_taken. Simultaneous requests: only the highest is used; the others are dropped silently.
- Target alignment:
  - Bits [1:0] of every target are forced to 0 before use.
  - If the raw target had nonzero [1:0], addr_err pulses high for the one cycle after the edge on which the target is applied to pcout.
- Arithmetic: pc_plus = pcout + INC, modulo 2^WIDTH. At the top of the space, pcout wraps to 0 with no flag.
- FSM states: RUN, PEND.
- RUN, stall = 0:
  - Request present: pcout <= aligned target next edge (1-cycle latency).
  - No request: pcout <= pc_plus.
  - Stays in RUN.
- RUN, stall = 1:
  - pcout held.
  - Request present: target latched into pend_reg, redirect_pending <= 1, go to PEND.
- PEND, stall = 1:
  - pcout held.
  - A new request overwrites pend_reg (newest wins). Stays in PEND.
- PEND, stall = 0:
  - A new request in the same cycle wins over pend_reg: pcout <= new target.
  - Otherwise pcout <= pend_reg.
  - redirect_pending <= 0, go to RUN. Never apply a sequential increment instead of the pending target.
- addr_err for a buffered target is evaluated when it is applied, not when it is latched.
- redirect_pending is registered and equals (state == PEND).

Optional Feature:
- Macro: PC_EXC_EN.
- Defined:
  - exc has highest priority and overrides stall.
  - On the edge: epc <= pcout, pcout <= EXC_VECTOR, pend_reg cleared, redirect_pending <= 0, FSM = RUN.
- Not defined:
  - exc port and epc output are absent (epc logic removed).
  - All other behaviour is unchanged.

Test Plan:
- Reset mid-cycle: assert reset between edges with pcout = 0x10 -> pcout = 0 immediately, before the next edge. Release reset, run 3 unstalled cycles -> pcout = 4, 8, 12.
- Branch: at pcout = 0x20, pulse branch_taken with target 0x400 -> next edge pcout = 0x400, then 0x404.
- Priority: pulse jr = 0x800, jump = 0x900 and branch_taken = 0xA00 together -> pcout = 0x800.
- Stall buffering:
  - stall = 1 at pcout = 0x100, pulse jump = 0x300 -> pcout holds 0x100, redirect_pending = 1.
  - Pulse branch = 0x500 while still stalled -> pend_reg = 0x500.
  - Release stall -> pcout = 0x500, redirect_pending = 0.
- Wrap and misalign:
  - pcout = 0xFFFF_FFFC, no request -> pcout = 0.
  - jr = 0x0000_1006 -> pcout = 0x1004, addr_err high exactly one cycle.
- PC_EXC_EN: stall = 1, pcout = 0x2000, exc pulse -> pcout = 0x180, epc = 0x2000, redirect_pending = 0.
